// File: rtl/nes_pkg.sv
// Shared NES constants and types.
// Bus addresses and the OAM DMA sequencer state enumeration.
package nes_pkg;

  localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
  localparam logic [15:0] OAMDATA_ADDR = 16'h2004;
  localparam int          OAM_DMA_LEN  = 256;

  typedef enum logic [2:0] {
    DMA_IDLE,
    DMA_HALT,
    DMA_ALIGN,
    DMA_READ,
    DMA_WRITE
  } dma_state_e;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA: copies one 256-byte CPU page to $2004 while holding the CPU.
// Sequencer and datapath update on the falling clock edge.
module oam_dma
  import nes_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_cs_n,
  input  logic        i_rw,
  input  logic [7:0]  i_data,
  input  logic [7:0]  i_bus_data,
  output logic        o_rdy,
  output logic        o_dma_active,
  output logic [15:0] o_address,
  output logic        o_rw,
  output logic [7:0]  o_data
);

  localparam logic [7:0] LAST_IDX = 8'(OAM_DMA_LEN - 1);

  dma_state_e state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] page_q, page_d;
  logic [7:0] latch_q, latch_d;
  logic       parity_q, parity_d;
  logic       strobe;

  assign strobe = !i_cs_n && !i_rw;

  always_ff @(negedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= DMA_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(negedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      idx_q    <= 8'h00;
      page_q   <= 8'h00;
      latch_q  <= 8'h00;
      parity_q <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      page_q   <= page_d;
      latch_q  <= latch_d;
      parity_q <= parity_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DMA_IDLE:  if (strobe) state_d = DMA_HALT;
      // reads must land on even cycles
      DMA_HALT:  state_d = parity_q ? DMA_READ : DMA_ALIGN;
      DMA_ALIGN: state_d = DMA_READ;
      DMA_READ:  state_d = DMA_WRITE;
      DMA_WRITE: state_d = (idx_q == LAST_IDX) ? DMA_IDLE : DMA_READ;
      default:   state_d = DMA_IDLE;
    endcase
  end

  always_comb begin
    idx_d    = idx_q;
    page_d   = page_q;
    latch_d  = latch_q;
    parity_d = !parity_q;
    unique case (state_q)
      DMA_IDLE: begin
        if (strobe) begin
          page_d = i_data;
          idx_d  = 8'h00;
        end
      end
      DMA_READ:  latch_d = i_bus_data;
      DMA_WRITE: idx_d   = idx_q + 8'h01;
      default: ;
    endcase
  end

  always_comb begin
    o_rdy        = 1'b0;
    o_dma_active = 1'b0;
    o_address    = 16'h0000;
    o_rw         = 1'b1;
    o_data       = 8'h00;
    unique case (state_q)
      DMA_IDLE: o_rdy = 1'b1;
      DMA_READ: begin
        o_dma_active = 1'b1;
        o_address    = {page_q, idx_q};
      end
      DMA_WRITE: begin
        o_dma_active = 1'b1;
        o_address    = OAMDATA_ADDR;
        o_rw         = 1'b0;
        o_data       = latch_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma.
// Expected bus cycles are queued at each strobe and popped as DMA runs.
module tb_oam_dma;

  typedef struct {
    logic [15:0] a;
    logic        rw;
    logic [7:0]  d;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_cs_n = 1'b1;
  logic        i_rw = 1'b1;
  logic [7:0]  i_data = 8'h00;
  logic [7:0]  i_bus_data;
  logic        o_rdy;
  logic        o_dma_active;
  logic [15:0] o_address;
  logic        o_rw;
  logic [7:0]  o_data;

  logic [7:0]  salt = 8'h00;
  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  bit          par = 1'b0;
  int          stall = 0;
  int          pre = 0;
  int          wr = 0;

  // memory model: byte = low address byte plus a per-test offset
  assign i_bus_data = o_address[7:0] + salt;

  always #5 i_clk = ~i_clk;

  oam_dma dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_cs_n       (i_cs_n),
    .i_rw         (i_rw),
    .i_data       (i_data),
    .i_bus_data   (i_bus_data),
    .o_rdy        (o_rdy),
    .o_dma_active (o_dma_active),
    .o_address    (o_address),
    .o_rw         (o_rw),
    .o_data       (o_data)
  );

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge i_clk);
    par = !par;
    if (!o_rdy) stall++;
    if (!o_rdy && !o_dma_active) pre++;
    if (o_dma_active) begin
      if (exp_q.size() == 0) begin
        check("unexpected_dma", 32'(o_address), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("addr", 32'(o_address), 32'(e.a));
        check("rw", 32'(o_rw), 32'(e.rw));
        if (!e.rw) begin
          check("wdata", 32'(o_data), 32'(e.d));
          wr++;
        end
      end
    end else begin
      check("idle_addr", 32'(o_address), 32'h0);
      check("idle_rw", 32'(o_rw), 32'h1);
      check("idle_data", 32'(o_data), 32'h0);
    end
  endtask

  task automatic push_xfer(input logic [7:0] pg, input logic [7:0] s);
    exp_t e;
    for (int i = 0; i < 256; i++) begin
      e.a = {pg, 8'(i)}; e.rw = 1'b1; e.d = 8'h00;
      exp_q.push_back(e);
      e.a = 16'h2004; e.rw = 1'b0; e.d = 8'(i) + s;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle_bus();
    i_cs_n = 1'b1; i_rw = 1'b1; i_data = 8'h00;
  endtask

  task automatic run_xfer(input logic [7:0] pg, input logic [7:0] s,
                          input bit halt_par, input bit poke);
    int n;
    // strobe lands one edge later, so HALT sees the inverted parity
    if (par == halt_par) tick();
    salt = s; stall = 0; pre = 0; wr = 0;
    push_xfer(pg, s);
    i_cs_n = 1'b0; i_rw = 1'b0; i_data = pg;
    tick();
    idle_bus();
    n = 0;
    while (!o_rdy && n < 600) begin
      if (poke && n == 100) begin
        i_cs_n = 1'b0; i_rw = 1'b0; i_data = 8'h77;
      end else begin
        idle_bus();
      end
      tick();
      n++;
    end
    idle_bus();
    check("xfer_done", 32'(o_rdy), 32'h1);
    check("stall_len", 32'(stall), halt_par ? 32'd513 : 32'd514);
    check("pre_cycles", 32'(pre), halt_par ? 32'd1 : 32'd2);
    check("writes", 32'(wr), 32'd256);
    check("q_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_rdy"}, 32'(o_rdy), 32'h1);
    check({tag, "_act"}, 32'(o_dma_active), 32'h0);
    check({tag, "_rw"}, 32'(o_rw), 32'h1);
    check({tag, "_addr"}, 32'(o_address), 32'h0);
    check({tag, "_data"}, 32'(o_data), 32'h0);
  endtask

  initial begin
    #2;
    check_reset_outs("reset");
    repeat (2) @(posedge i_clk);
    i_reset_n = 1'b1;
    par = 1'b0;

    // reads and writes that are not strobes
    tick();
    i_cs_n = 1'b0; i_rw = 1'b1; i_data = 8'h11;
    tick();
    i_cs_n = 1'b1; i_rw = 1'b0; i_data = 8'h22;
    tick();
    idle_bus();
    tick();
    check("nostrobe_rdy", 32'(o_rdy), 32'h1);
    check("nostrobe_act", 32'(o_dma_active), 32'h0);

    run_xfer(8'h02, 8'h5A, 1'b1, 1'b0);
    run_xfer(8'h40, 8'h13, 1'b0, 1'b0);
    // restrike immediately in the first IDLE cycle
    run_xfer(8'hFF, 8'h00, !par, 1'b0);
    // second strobe mid-transfer must be ignored
    run_xfer(8'h10, 8'hC3, 1'b1, 1'b1);

    // reset mid-transfer at idx 0x80
    salt = 8'h21; wr = 0;
    push_xfer(8'h05, 8'h21);
    i_cs_n = 1'b0; i_rw = 1'b0; i_data = 8'h05;
    tick();
    idle_bus();
    for (int n = 0; n < 400 && wr < 128; n++) tick();
    check("mid_wr", 32'(wr), 32'd128);
    tick();
    i_reset_n = 1'b0;
    #1;
    check_reset_outs("midrst");
    exp_q.delete();
    #1;
    i_reset_n = 1'b1;
    par = 1'b0;
    repeat (3) tick();
    check("no_resume", 32'(o_rdy), 32'h1);
    run_xfer(8'h03, 8'h44, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
